branch_target_buffer: RTL and testbench

//  Direct-mapped branch target buffer for the fetch-stage hybrid predictor.

---
 rtl/branch_target_buffer.sv | 64 ++++++
 tb/tb_branch_target_buffer.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/branch_target_buffer.sv
// Direct-mapped branch target buffer: zero-latency lookup of the fetch PC,
// trained by taken branches resolved in MEM.
module branch_target_buffer #(
  parameter int INDEX_BITS = 6,
  parameter int TAG_BITS   = 30 - INDEX_BITS
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        FLUSH,
  input  logic        Resolution_IN,
  input  logic [31:0] Branch_addr_IN,
  input  logic [31:0] Branch_resolved_addr_IN,
  input  logic [31:0] Instr_Addr_IN,
  input  logic        Is_Branch_IN,
  output logic [31:0] Addr_OUT,
  output logic        Valid_OUT
);

  localparam int ENTRIES = 1 << INDEX_BITS;

  logic [ENTRIES-1:0]  valid;
  logic [TAG_BITS-1:0] tag_mem    [ENTRIES];
  logic [31:0]         target_mem [ENTRIES];

  logic [INDEX_BITS-1:0] look_idx;
  logic [TAG_BITS-1:0]   look_tag;
  logic [INDEX_BITS-1:0] wr_idx;
  logic [TAG_BITS-1:0]   wr_tag;
  logic                  wr_en;
  logic                  hit;

  // Byte-offset bits of both PCs never reach the table.
  logic unused_pc_low;
  assign unused_pc_low = ^{Instr_Addr_IN[1:0], Branch_addr_IN[1:0]};

  assign look_idx = Instr_Addr_IN[INDEX_BITS+1:2];
  assign look_tag = Instr_Addr_IN[31:INDEX_BITS+2];
  assign wr_idx   = Branch_addr_IN[INDEX_BITS+1:2];
  assign wr_tag   = Branch_addr_IN[31:INDEX_BITS+2];

  assign wr_en = RESET && !FLUSH && Resolution_IN && (Branch_addr_IN != 32'd0);

  // Reads see pre-edge contents; a write becomes visible on the next cycle.
  assign hit       = valid[look_idx] && (tag_mem[look_idx] == look_tag);
  assign Valid_OUT = hit && Is_Branch_IN && !FLUSH;
  assign Addr_OUT  = Valid_OUT ? target_mem[look_idx] : 32'd0;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      valid <= '0;
    end else if (wr_en) begin
      valid[wr_idx] <= 1'b1;
    end
  end

  // Tag and target need no reset: the valid bit gates every use.
  always_ff @(posedge CLK) begin
    if (wr_en) begin
      tag_mem[wr_idx]    <= wr_tag;
      target_mem[wr_idx] <= Branch_resolved_addr_IN;
    end
  end

endmodule

// File: tb/tb_branch_target_buffer.sv
// Self-checking bench for branch_target_buffer: directed cases followed by
// randomized traffic compared against a PC-keyed reference table.
module tb_branch_target_buffer;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        FLUSH;
  logic        Resolution_IN;
  logic [31:0] Branch_addr_IN;
  logic [31:0] Branch_resolved_addr_IN;
  logic [31:0] Instr_Addr_IN;
  logic        Is_Branch_IN;
  logic [31:0] Addr_OUT;
  logic        Valid_OUT;

  int errors = 0;
  int checks = 0;

  // Reference: for each of 64 slots, the word address of the last branch
  // learned there and its target.
  bit          m_valid [64];
  logic [29:0] m_word  [64];
  logic [31:0] m_tgt   [64];

  int unsigned tags [4] = '{32'h004000, 32'h004001, 32'h00802A, 32'hFFFFFF};

  branch_target_buffer dut (
    .CLK                     (CLK),
    .RESET                   (RESET),
    .FLUSH                   (FLUSH),
    .Resolution_IN           (Resolution_IN),
    .Branch_addr_IN          (Branch_addr_IN),
    .Branch_resolved_addr_IN (Branch_resolved_addr_IN),
    .Instr_Addr_IN           (Instr_Addr_IN),
    .Is_Branch_IN            (Is_Branch_IN),
    .Addr_OUT                (Addr_OUT),
    .Valid_OUT               (Valid_OUT)
  );

  always #5 CLK = ~CLK;

  function automatic void model_clear();
    for (int i = 0; i < 64; i++) m_valid[i] = 1'b0;
  endfunction

  function automatic void model_lookup(input logic [31:0] pc, input logic isb,
                                       input logic fl, output logic v,
                                       output logic [31:0] a);
    int slot;
    slot = int'((pc / 4) % 64);
    v = isb && !fl && m_valid[slot] && (m_word[slot] / 64 == (pc / 4) / 64);
    a = v ? m_tgt[slot] : 32'd0;
  endfunction

  task automatic check(input string name, input logic v_obs, input logic v_exp,
                       input logic [31:0] a_obs, input logic [31:0] a_exp);
    checks++;
    assert (v_obs === v_exp) else begin
      errors++;
      $error("FAIL %s valid observed=%0b expected=%0b", name, v_obs, v_exp);
    end
    checks++;
    assert (a_obs === a_exp) else begin
      errors++;
      $error("FAIL %s addr observed=%h expected=%h", name, a_obs, a_exp);
    end
  endtask

  // One cycle, entered just after a negedge: drive, check the lookup against the
  // model (and optionally constants), take the posedge, advance the model.
  task automatic step(input string name, input logic [31:0] pc, input logic isb,
                      input logic fl, input logic res, input logic [31:0] baddr,
                      input logic [31:0] tgt, input int cv, input logic [31:0] ca);
    logic        ev;
    logic [31:0] ea;
    Instr_Addr_IN = pc;
    Is_Branch_IN = isb;
    FLUSH = fl;
    Resolution_IN = res;
    Branch_addr_IN = baddr;
    Branch_resolved_addr_IN = tgt;
    #1;
    model_lookup(pc, isb, fl, ev, ea);
    check(name, Valid_OUT, ev, Addr_OUT, ea);
    if (cv >= 0) check({name, "_const"}, Valid_OUT, cv[0], Addr_OUT, ca);
    @(posedge CLK);
    if (RESET && !fl && res && baddr != 32'd0) begin
      m_valid[(baddr / 4) % 64] = 1'b1;
      m_word[(baddr / 4) % 64]  = baddr[31:2];
      m_tgt[(baddr / 4) % 64]   = tgt;
    end
    @(negedge CLK);
  endtask

  initial begin
    logic [31:0] pc, ba;
    model_clear();
    RESET = 1'b0;
    FLUSH = 1'b0;
    Resolution_IN = 1'b0;
    Branch_addr_IN = 32'd0;
    Branch_resolved_addr_IN = 32'd0;
    Instr_Addr_IN = 32'h0040_0020;
    Is_Branch_IN = 1'b1;
    #1;
    check("reset_lookup", Valid_OUT, 1'b0, Addr_OUT, 32'd0);
    @(negedge CLK);
    RESET = 1'b1;
    #1;
    check("after_release", Valid_OUT, 1'b0, Addr_OUT, 32'd0);

    step("learn",        32'h0040_0020, 1, 0, 1, 32'h0040_0020, 32'h0040_0100, 0, 32'd0);
    step("learn_hit",    32'h0040_0020, 1, 0, 0, 32'd0, 32'd0, 1, 32'h0040_0100);
    step("not_branch",   32'h0040_0020, 0, 0, 0, 32'd0, 32'd0, 0, 32'd0);
    step("alias_miss",   32'h0040_0120, 1, 0, 1, 32'h0040_0120, 32'h0040_0200, 0, 32'd0);
    step("evicted",      32'h0040_0020, 1, 0, 0, 32'd0, 32'd0, 0, 32'd0);
    step("alias_hit",    32'h0040_0120, 1, 0, 0, 32'h0040_0020, 32'h1111_1110, 1, 32'h0040_0200);
    step("not_taken",    32'h0040_0120, 1, 0, 1, 32'd0, 32'h3333_3330, 1, 32'h0040_0200);
    step("zero_baddr",   32'h0000_0000, 1, 0, 1, 32'h0040_0120, 32'h2222_2220, 0, 32'd0);
    step("flush_upd",    32'h0040_0120, 1, 1, 0, 32'd0, 32'd0, 0, 32'd0);
    step("flush_kept",   32'h0040_0120, 1, 0, 0, 32'd0, 32'd0, 1, 32'h2222_2220);
    step("same_cycle",   32'h0040_0040, 1, 0, 1, 32'h0040_0040, 32'h0040_0300, 0, 32'd0);
    step("next_cycle",   32'h0040_0040, 1, 0, 0, 32'd0, 32'd0, 1, 32'h0040_0300);
    step("zero_target",  32'h0040_0080, 1, 0, 1, 32'h0040_0082, 32'd0, 0, 32'd0);
    step("zero_tgt_hit", 32'h0040_0081, 1, 0, 0, 32'd0, 32'd0, 1, 32'd0);
    step("low_bits",     32'h0040_0043, 1, 0, 0, 32'd0, 32'd0, 1, 32'h0040_0300);

    // Asynchronous reset between edges.
    Instr_Addr_IN = 32'h0040_0040;
    Is_Branch_IN = 1'b1;
    #1;
    check("pre_async", Valid_OUT, 1'b1, Addr_OUT, 32'h0040_0300);
    RESET = 1'b0;
    #1;
    check("async_drop", Valid_OUT, 1'b0, Addr_OUT, 32'd0);
    model_clear();
    #1;
    RESET = 1'b1;
    @(negedge CLK);
    step("post_rst_a", 32'h0040_0040, 1, 0, 0, 32'd0, 32'd0, 0, 32'd0);
    step("post_rst_b", 32'h0040_0120, 1, 0, 0, 32'd0, 32'd0, 0, 32'd0);

    for (int i = 0; i < 400; i++) begin
      pc = (32'(tags[$urandom_range(0, 3)]) << 8) | (32'($urandom_range(0, 7)) << 2)
           | 32'($urandom_range(0, 3));
      ba = (32'(tags[$urandom_range(0, 3)]) << 8) | (32'($urandom_range(0, 7)) << 2)
           | 32'($urandom_range(0, 3));
      if ($urandom_range(0, 9) == 0) ba = 32'd0;
      step("random", pc, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 7) == 0),
           1'($urandom_range(0, 1)), ba, $urandom, -1, 32'd0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
